// File: rtl/id_ir_src_reg.sv
// ID-stage instruction register: picks one of NUM_SRC fetch sources, holds on stall,
// and presents BUBBLE_CYCLES NOP words after every flush.
module id_ir_src_reg #(
  parameter int                DATA_W        = 32,
  parameter int                NUM_SRC       = 4,
  parameter logic [DATA_W-1:0] NOP_WORD      = 32'h0000_0000,
  parameter int                BUBBLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_SRC)-1:0]  sel,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic                        stall,
  input  logic                        flush,
  output logic [DATA_W-1:0]           ir_out,
  output logic                        ir_valid,
  output logic                        bubble_active,
  output logic                        sel_err
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam logic [3:0] CNT_LOAD = 4'(BUBBLE_CYCLES - 1);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_BUBBLE = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_ir;
  logic              r_valid;
  logic              r_bubble;
  logic              r_err;

  state_t            w_state_nxt;
  logic [3:0]        w_cnt_nxt;
  logic [DATA_W-1:0] w_ir_nxt;
  logic              w_valid_nxt;
  logic              w_err_nxt;
  logic [DATA_W-1:0] w_src_word;
  logic              w_sel_ok;

  // Source mux; w_sel_ok stays low for select codes with no backing source.
  always_comb begin
    w_src_word = NOP_WORD;
    w_sel_ok   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_src_word = (sel == SEL_W'(k)) ? src_data[k*DATA_W +: DATA_W] : w_src_word;
      w_sel_ok   = w_sel_ok | (sel == SEL_W'(k));
    end
  end

  // Next-state and next-output logic; flush outranks stall and the countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ir_nxt    = r_ir;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    if (flush) begin
      w_ir_nxt    = NOP_WORD;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = CNT_LOAD;
      w_state_nxt = (BUBBLE_CYCLES > 1) ? S_BUBBLE : S_RUN;
    end else if (stall) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_sel_ok) begin
            w_ir_nxt    = w_src_word;
            w_valid_nxt = 1'b1;
          end else begin
            w_ir_nxt    = NOP_WORD;
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b1;
          end
        end
        S_BUBBLE: begin
          w_ir_nxt    = NOP_WORD;
          w_valid_nxt = 1'b0;
          // A zero count here is unreachable but must never trap the FSM.
          if (r_cnt <= 4'd1) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt   = r_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 4'd0;
          w_ir_nxt    = NOP_WORD;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_cnt    <= 4'd0;
      r_ir     <= NOP_WORD;
      r_valid  <= 1'b0;
      r_bubble <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ir     <= w_ir_nxt;
      r_valid  <= w_valid_nxt;
      r_bubble <= (w_state_nxt == S_BUBBLE);
      r_err    <= w_err_nxt;
    end
  end

  assign ir_out        = r_ir;
  assign ir_valid      = r_valid;
  assign bubble_active = r_bubble;
  assign sel_err       = r_err;

endmodule

// File: tb/tb_id_ir_src_reg.sv
// Bench for id_ir_src_reg (3 sources, 3 bubble words): directed scenarios with literal
// expectations plus a randomized run checked every cycle against a behavioural model.
module tb_id_ir_src_reg;

  localparam int          DW  = 32;
  localparam int          NS  = 3;
  localparam int          BC  = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [1:0]     sel = 2'd0;
  logic [NS*DW-1:0] src_data = '0;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic [DW-1:0]  ir_out;
  logic           ir_valid;
  logic           bubble_active;
  logic           sel_err;

  int n_cmp = 0;
  int n_bad = 0;

  id_ir_src_reg #(
    .DATA_W(DW), .NUM_SRC(NS), .NOP_WORD(NOP), .BUBBLE_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .src_data(src_data), .stall(stall), .flush(flush),
    .ir_out(ir_out), .ir_valid(ir_valid), .bubble_active(bubble_active), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: m_left counts NOP words still owed after the current one.
  logic [31:0] m_ir    = NOP;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  int          m_left  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ir <= NOP; m_valid <= 1'b0; m_err <= 1'b0; m_left <= 0;
    end else if (flush) begin
      m_ir <= NOP; m_valid <= 1'b0; m_left <= BC - 1;
    end else if (stall) begin
      m_left <= m_left;
    end else if (m_left > 0) begin
      m_ir <= NOP; m_valid <= 1'b0; m_left <= m_left - 1;
    end else if (int'(sel) < NS) begin
      m_ir <= src_data[int'(sel)*DW +: DW]; m_valid <= 1'b1;
    end else begin
      m_ir <= NOP; m_valid <= 1'b0; m_err <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model ir_out", ir_out, m_ir);
    chk("model ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
    chk("model bubble_active", {31'd0, bubble_active}, {31'd0, (m_left > 0)});
    chk("model sel_err", {31'd0, sel_err}, {31'd0, m_err});
  end

  // Drive one cycle of inputs just after a falling edge, return at the next falling edge.
  task automatic drive(input logic [1:0] s, input logic st, input logic fl,
                       input logic [NS*DW-1:0] d);
    #1;
    sel = s; stall = st; flush = fl; src_data = d;
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic [31:0] ir, input logic v,
                         input logic b, input logic e);
    chk({name, " ir"}, ir_out, ir);
    chk({name, " valid"}, {31'd0, ir_valid}, {31'd0, v});
    chk({name, " bubble"}, {31'd0, bubble_active}, {31'd0, b});
    chk({name, " err"}, {31'd0, sel_err}, {31'd0, e});
  endtask

  logic [NS*DW-1:0] d;

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk_out("reset", NOP, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    d = {32'h0, 32'h0, 32'h1234_5678};
    drive(2'd0, 1'b0, 1'b0, d); chk_out("first load", 32'h1234_5678, 1'b1, 1'b0, 1'b0);

    d = {32'h0, 32'hCAFE_0001, 32'h0};
    drive(2'd1, 1'b0, 1'b1, d); chk_out("flush nop1", NOP, 1'b0, 1'b1, 1'b0);
    drive(2'd1, 1'b0, 1'b0, d); chk_out("flush nop2", NOP, 1'b0, 1'b1, 1'b0);
    drive(2'd1, 1'b0, 1'b0, d); chk_out("flush nop3", NOP, 1'b0, 1'b0, 1'b0);
    drive(2'd1, 1'b0, 1'b0, d); chk_out("post bubble", 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);

    d = {32'h5555_AAAA, 32'h0, 32'h0};
    drive(2'd2, 1'b0, 1'b1, d); chk_out("stall bub1", NOP, 1'b0, 1'b1, 1'b0);
    drive(2'd2, 1'b0, 1'b0, d); chk_out("stall bub2", NOP, 1'b0, 1'b1, 1'b0);
    drive(2'd2, 1'b1, 1'b0, d); chk_out("stall bub3", NOP, 1'b0, 1'b1, 1'b0);
    drive(2'd2, 1'b1, 1'b0, d); chk_out("stall bub4", NOP, 1'b0, 1'b1, 1'b0);
    drive(2'd2, 1'b0, 1'b0, d); chk_out("stall bub5", NOP, 1'b0, 1'b0, 1'b0);
    drive(2'd2, 1'b0, 1'b0, d); chk_out("stall after", 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);

    d = {32'h0, 32'h0, 32'hAAAA_0001};
    drive(2'd0, 1'b0, 1'b0, d); chk_out("pre stall+flush", 32'hAAAA_0001, 1'b1, 1'b0, 1'b0);
    drive(2'd0, 1'b1, 1'b1, d); chk_out("stall+flush", NOP, 1'b0, 1'b1, 1'b0);
    drive(2'd0, 1'b0, 1'b0, d);
    drive(2'd0, 1'b0, 1'b0, d); chk_out("stall+flush end", NOP, 1'b0, 1'b0, 1'b0);

    d = {32'h0, 32'h0, 32'h0BAD_F00D};
    drive(2'd3, 1'b0, 1'b0, d); chk_out("illegal sel", NOP, 1'b0, 1'b0, 1'b1);
    drive(2'd0, 1'b0, 1'b0, d); chk_out("sticky err", 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1);

    drive(2'd0, 1'b0, 1'b1, d); chk_out("pre async rst", NOP, 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 chk_out("async rst", NOP, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    d = {32'hDEAD_BEEF, 32'h0, 32'h0};
    drive(2'd2, 1'b0, 1'b0, d); chk_out("after rst", 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);

    #1 rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(2'd2, 1'b0, 1'b1, d); chk_out("flush at release", NOP, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      #1;
      rst      = ($urandom_range(0, 99) == 0);
      sel      = 2'($urandom_range(0, 3));
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      src_data = {$urandom, $urandom, $urandom};
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
